// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control unit with a memory ready handshake.
// A state register plus combinational decode of state, opcode, funct, Zero
// and mem_rdy. Illegal opcodes and memory stalls that run past TIMEOUT_CYC
// cycles trap into a sticky error state that only rst leaves.
module mc_ctrl_hs #(
  parameter int ALUOP_W     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_rdy,
  output logic               mem_req,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               EXTOp,
  output logic               IorD,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               Exc,
  output logic [1:0]         ExcCode,
  output logic [2:0]         state_o
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ILL  = 2'd1,
    EXC_TMO  = 2'd2
  } exc_e;

  // Instruction classes that share one sequencing path through the FSM.
  typedef enum logic [3:0] {
    C_RALU, C_SHAMT, C_JR, C_JALR, C_IALU, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } cls_e;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_q, exc_d;
  exc_e             exc_code_q, exc_code_d;

  cls_e             cls;
  logic [3:0]       alu_dec;
  logic             ext_dec;
  logic [3:0]       alu_op;
  logic             stalled;
  logic             wd_hit;
  exc_e             trap_cause;

  // Decode opcode/funct into an instruction class, its EXE ALU op and extension.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cls     = C_ILL;
    alu_dec = ALU_ADD;
    ext_dec = 1'b1;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21: begin cls = C_RALU;  alu_dec = ALU_ADD;  end
          6'h22, 6'h23: begin cls = C_RALU;  alu_dec = ALU_SUB;  end
          6'h24:        begin cls = C_RALU;  alu_dec = ALU_AND;  end
          6'h25:        begin cls = C_RALU;  alu_dec = ALU_OR;   end
          6'h27:        begin cls = C_RALU;  alu_dec = ALU_NOR;  end
          6'h2A:        begin cls = C_RALU;  alu_dec = ALU_SLT;  end
          6'h2B:        begin cls = C_RALU;  alu_dec = ALU_SLTU; end
          6'h00:        begin cls = C_SHAMT; alu_dec = ALU_SLL;  end
          6'h02:        begin cls = C_SHAMT; alu_dec = ALU_SRL;  end
          6'h04:        begin cls = C_RALU;  alu_dec = ALU_SLLV; end
          6'h06:        begin cls = C_RALU;  alu_dec = ALU_SRLV; end
          6'h08:        cls = C_JR;
          6'h09:        cls = C_JALR;
          default:      cls = C_ILL;
        endcase
      end
      6'h08:   begin cls = C_IALU; alu_dec = ALU_ADD; end
      6'h0C:   begin cls = C_IALU; alu_dec = ALU_AND; ext_dec = 1'b0; end
      6'h0D:   begin cls = C_IALU; alu_dec = ALU_OR;  ext_dec = 1'b0; end
      6'h0A:   begin cls = C_IALU; alu_dec = ALU_SLT; end
      6'h0F:   begin cls = C_IALU; alu_dec = ALU_LUI; ext_dec = 1'b0; end
      6'h23:   cls = C_LW;
      6'h2B:   cls = C_SW;
      6'h04:   begin cls = C_BEQ; alu_dec = ALU_SUB; end
      6'h05:   begin cls = C_BNE; alu_dec = ALU_SUB; end
      6'h02:   cls = C_J;
      6'h03:   cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  // Next state, control outputs, watchdog and exception bookkeeping.
  always_comb begin
    state_d    = state_q;
    trap_cause = EXC_NONE;
    mem_req    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    EXTOp      = 1'b1;
    IorD       = 1'b0;
    ALUSrcA    = 2'd1;
    ALUSrcB    = 2'd0;
    alu_op     = ALU_ADD;
    PCSource   = 2'd0;
    GPRSel     = 2'd0;
    WDSel      = 2'd0;

    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        ALUSrcA = 2'd0;
        ALUSrcB = 2'd1;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        if (mem_rdy) state_d = S_ID;
      end
      S_ID: begin
        case (cls)
          C_J: begin
            PCSource = 2'd2; PCWrite = 1'b1; state_d = S_IF;
          end
          C_JAL: begin
            PCSource = 2'd2; PCWrite = 1'b1;
            RegWrite = 1'b1; GPRSel = 2'd2; WDSel = 2'd2; state_d = S_IF;
          end
          C_JR: begin
            PCSource = 2'd3; PCWrite = 1'b1; state_d = S_IF;
          end
          C_JALR: begin
            PCSource = 2'd3; PCWrite = 1'b1;
            RegWrite = 1'b1; GPRSel = 2'd0; WDSel = 2'd2; state_d = S_IF;
          end
          C_ILL: begin
            state_d    = S_ERR;
            trap_cause = EXC_ILL;
          end
          default: begin
            // Precompute the branch target while the operands are read.
            ALUSrcA = 2'd0; ALUSrcB = 2'd3; state_d = S_EXE;
          end
        endcase
      end
      S_EXE: begin
        alu_op = alu_dec;
        EXTOp  = ext_dec;
        case (cls)
          C_BEQ:       begin PCSource = 2'd1; PCWrite = Zero;  state_d = S_IF; end
          C_BNE:       begin PCSource = 2'd1; PCWrite = ~Zero; state_d = S_IF; end
          C_LW, C_SW:  begin ALUSrcB = 2'd2; state_d = S_MEM; end
          C_SHAMT:     begin ALUSrcA = 2'd2; state_d = S_WB;  end
          C_IALU:      begin ALUSrcB = 2'd2; state_d = S_WB;  end
          default:     state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = (cls == C_SW) & mem_rdy;
        if (mem_rdy) state_d = (cls == C_SW) ? S_IF : S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (cls == C_LW || cls == C_IALU) ? 2'd1 : 2'd0;
        WDSel    = (cls == C_LW) ? 2'd1 : 2'd0;
        state_d  = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IF;
    endcase

    // Watchdog: count consecutive stalled cycles of one memory access.
    // A ready in the match cycle completes the access, so it never trips.
    stalled = (state_q == S_IF || state_q == S_MEM) && !mem_rdy;
    wd_hit  = (TIMEOUT_CYC != 0) && stalled && (cnt_q == CNT_W'(TIMEOUT_CYC));
    if (wd_hit) begin
      state_d    = S_ERR;
      trap_cause = EXC_TMO;
    end
    cnt_d = (stalled && !wd_hit) ? cnt_q + CNT_W'(1) : '0;

    exc_d      = exc_q;
    exc_code_d = exc_code_q;
    if (state_d == S_ERR && state_q != S_ERR) begin
      exc_d      = 1'b1;
      exc_code_d = trap_cause;
    end

    // Reset aborts the instruction in flight: nothing may be written while it is held.
    if (rst) begin
      mem_req  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
    end

    ALUOp   = ALUOP_W'(alu_op);
    Exc     = exc_q;
    ExcCode = exc_code_q;
    state_o = state_q;
  end

  // State, watchdog counter and sticky exception registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IF;
      cnt_q      <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exc_q      <= exc_d;
      exc_code_q <= exc_code_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: the driver applies one cycle of inputs and
// queues the hand-computed control vector for that cycle; the monitor pops
// and compares on each falling edge.
module tb_mc_ctrl_hs;

  localparam int AW = 5;

  typedef struct packed {
    logic [2:0]    st;
    logic          mem_req;
    logic          reg_write;
    logic          mem_write;
    logic          pc_write;
    logic          ir_write;
    logic          iord;
    logic          ext_op;
    logic [1:0]    src_a;
    logic [1:0]    src_b;
    logic [AW-1:0] alu_op;
    logic [1:0]    pc_src;
    logic [1:0]    gpr_sel;
    logic [1:0]    wd_sel;
    logic          exc;
    logic [1:0]    exc_code;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, Zero, mem_rdy;
  logic [5:0]    Op, Funct;
  logic          mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD;
  logic [1:0]    ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, ExcCode;
  logic [AW-1:0] ALUOp;
  logic          Exc;
  logic [2:0]    state_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mc_ctrl_hs #(.ALUOP_W(AW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .EXTOp(EXTOp), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel),
    .Exc(Exc), .ExcCode(ExcCode), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected-vector builders: defaults, then per-state fields.
  function automatic ctl_t cd(input logic [2:0] st);
    cd        = '0;
    cd.st     = st;
    cd.ext_op = 1'b1;
    cd.src_a  = 2'd1;
    cd.alu_op = 5'd1;
  endfunction

  function automatic ctl_t c_if(input logic rdy);
    c_if          = cd(3'd0);
    c_if.mem_req  = 1'b1;
    c_if.src_a    = 2'd0;
    c_if.src_b    = 2'd1;
    c_if.ir_write = rdy;
    c_if.pc_write = rdy;
  endfunction

  function automatic ctl_t c_rst();
    c_rst         = c_if(1'b0);
    c_rst.mem_req = 1'b0;
  endfunction

  function automatic ctl_t c_id();
    c_id       = cd(3'd1);
    c_id.src_a = 2'd0;
    c_id.src_b = 2'd3;
  endfunction

  function automatic ctl_t c_jmp(input logic [1:0] pcs, input logic link, input logic [1:0] gpr);
    c_jmp          = cd(3'd1);
    c_jmp.pc_src   = pcs;
    c_jmp.pc_write = 1'b1;
    if (link) begin
      c_jmp.reg_write = 1'b1;
      c_jmp.wd_sel    = 2'd2;
      c_jmp.gpr_sel   = gpr;
    end
  endfunction

  function automatic ctl_t c_exe(input logic [4:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic ext);
    c_exe        = cd(3'd2);
    c_exe.alu_op = alu;
    c_exe.src_a  = sa;
    c_exe.src_b  = sb;
    c_exe.ext_op = ext;
  endfunction

  function automatic ctl_t c_br(input logic pcw);
    c_br          = cd(3'd2);
    c_br.alu_op   = 5'd2;
    c_br.pc_src   = 2'd1;
    c_br.pc_write = pcw;
  endfunction

  function automatic ctl_t c_mem(input logic mw);
    c_mem           = cd(3'd3);
    c_mem.mem_req   = 1'b1;
    c_mem.iord      = 1'b1;
    c_mem.mem_write = mw;
  endfunction

  function automatic ctl_t c_wb(input logic [1:0] gpr, input logic [1:0] wd);
    c_wb           = cd(3'd4);
    c_wb.reg_write = 1'b1;
    c_wb.gpr_sel   = gpr;
    c_wb.wd_sel    = wd;
  endfunction

  function automatic ctl_t c_err(input logic [1:0] code);
    c_err          = cd(3'd7);
    c_err.exc      = 1'b1;
    c_err.exc_code = code;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must present in it.
  task automatic step(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input ctl_t e);
    exp_t x;
    rst     = r;
    Op      = op;
    Funct   = fn;
    Zero    = z;
    mem_rdy = rdy;
    x.name  = nm;
    x.c     = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the queued vector against the live outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      ctl_t act;
      x             = exp_q.pop_front();
      act.st        = state_o;
      act.mem_req   = mem_req;
      act.reg_write = RegWrite;
      act.mem_write = MemWrite;
      act.pc_write  = PCWrite;
      act.ir_write  = IRWrite;
      act.iord      = IorD;
      act.ext_op    = EXTOp;
      act.src_a     = ALUSrcA;
      act.src_b     = ALUSrcB;
      act.alu_op    = ALUOp;
      act.pc_src    = PCSource;
      act.gpr_sel   = GPRSel;
      act.wd_sel    = WDSel;
      act.exc       = Exc;
      act.exc_code  = ExcCode;
      checks++;
      if (act !== x.c) begin
        errors++;
        $display("FAIL %s: got ctl=%h (state %0d) expected ctl=%h (state %0d)",
                 x.name, act, act.st, x.c, x.c.st);
      end
    end
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_rdy = 1'b1;
    @(posedge clk);
    #1;
    // Second reset cycle: state IF, all enables forced low.
    step("reset",      1, 6'h00, 6'h00, 0, 1, c_rst());

    // addu $3,$1,$2
    step("addu_if",    0, 6'h00, 6'h21, 0, 1, c_if(1));
    step("addu_id",    0, 6'h00, 6'h21, 0, 1, c_id());
    step("addu_exe",   0, 6'h00, 6'h21, 0, 1, c_exe(5'd1, 2'd1, 2'd0, 1));
    step("addu_wb",    0, 6'h00, 6'h21, 0, 1, c_wb(2'd0, 2'd0));

    // lw with three MEM stall cycles: 8 cycles total
    step("lw_if",      0, 6'h23, 6'h00, 0, 1, c_if(1));
    step("lw_id",      0, 6'h23, 6'h00, 0, 1, c_id());
    step("lw_exe",     0, 6'h23, 6'h00, 0, 1, c_exe(5'd1, 2'd1, 2'd2, 1));
    for (int i = 0; i < 3; i++)
      step("lw_mem_stall", 0, 6'h23, 6'h00, 0, 0, c_mem(0));
    step("lw_mem_rdy", 0, 6'h23, 6'h00, 0, 1, c_mem(0));
    step("lw_wb",      0, 6'h23, 6'h00, 0, 1, c_wb(2'd1, 2'd1));

    // sw: one IF stall; mem_rdy low in ID/EXE must be ignored
    step("sw_if_stall",0, 6'h2B, 6'h00, 0, 0, c_if(0));
    step("sw_if",      0, 6'h2B, 6'h00, 0, 1, c_if(1));
    step("sw_id",      0, 6'h2B, 6'h00, 0, 0, c_id());
    step("sw_exe",     0, 6'h2B, 6'h00, 0, 0, c_exe(5'd1, 2'd1, 2'd2, 1));
    step("sw_mem",     0, 6'h2B, 6'h00, 0, 1, c_mem(1));

    // bne Zero=0 (taken), beq Zero=0 (not taken), beq Zero=1 (taken)
    step("bne_if",     0, 6'h05, 6'h00, 0, 1, c_if(1));
    step("bne_id",     0, 6'h05, 6'h00, 0, 1, c_id());
    step("bne_exe_z0", 0, 6'h05, 6'h00, 0, 1, c_br(1));
    step("beq_if",     0, 6'h04, 6'h00, 0, 1, c_if(1));
    step("beq_id",     0, 6'h04, 6'h00, 0, 1, c_id());
    step("beq_exe_z0", 0, 6'h04, 6'h00, 0, 1, c_br(0));
    step("beq2_if",    0, 6'h04, 6'h00, 1, 1, c_if(1));
    step("beq2_id",    0, 6'h04, 6'h00, 1, 1, c_id());
    step("beq_exe_z1", 0, 6'h04, 6'h00, 1, 1, c_br(1));

    // jalr $5 and jal
    step("jalr_if",    0, 6'h00, 6'h09, 0, 1, c_if(1));
    step("jalr_id",    0, 6'h00, 6'h09, 0, 1, c_jmp(2'd3, 1, 2'd0));
    step("jal_if",     0, 6'h03, 6'h00, 0, 1, c_if(1));
    step("jal_id",     0, 6'h03, 6'h00, 0, 1, c_jmp(2'd2, 1, 2'd2));

    // I-type ALU: andi / slti / lui
    step("andi_if",    0, 6'h0C, 6'h00, 0, 1, c_if(1));
    step("andi_id",    0, 6'h0C, 6'h00, 0, 1, c_id());
    step("andi_exe",   0, 6'h0C, 6'h00, 0, 1, c_exe(5'd3, 2'd1, 2'd2, 0));
    step("andi_wb",    0, 6'h0C, 6'h00, 0, 1, c_wb(2'd1, 2'd0));
    step("slti_if",    0, 6'h0A, 6'h00, 0, 1, c_if(1));
    step("slti_id",    0, 6'h0A, 6'h00, 0, 1, c_id());
    step("slti_exe",   0, 6'h0A, 6'h00, 0, 1, c_exe(5'd5, 2'd1, 2'd2, 1));
    step("slti_wb",    0, 6'h0A, 6'h00, 0, 1, c_wb(2'd1, 2'd0));
    step("lui_if",     0, 6'h0F, 6'h00, 0, 1, c_if(1));
    step("lui_id",     0, 6'h0F, 6'h00, 0, 1, c_id());
    step("lui_exe",    0, 6'h0F, 6'h00, 0, 1, c_exe(5'd10, 2'd1, 2'd2, 0));
    step("lui_wb",     0, 6'h0F, 6'h00, 0, 1, c_wb(2'd1, 2'd0));

    // Shifts: sll uses shamt, sllv uses a register amount
    step("sll_if",     0, 6'h00, 6'h00, 0, 1, c_if(1));
    step("sll_id",     0, 6'h00, 6'h00, 0, 1, c_id());
    step("sll_exe",    0, 6'h00, 6'h00, 0, 1, c_exe(5'd7, 2'd2, 2'd0, 1));
    step("sll_wb",     0, 6'h00, 6'h00, 0, 1, c_wb(2'd0, 2'd0));
    step("sllv_if",    0, 6'h00, 6'h04, 0, 1, c_if(1));
    step("sllv_id",    0, 6'h00, 6'h04, 0, 1, c_id());
    step("sllv_exe",   0, 6'h00, 6'h04, 0, 1, c_exe(5'd11, 2'd1, 2'd0, 1));
    step("sllv_wb",    0, 6'h00, 6'h04, 0, 1, c_wb(2'd0, 2'd0));

    // Illegal opcode: ERR, sticky, cleared only by rst
    step("ill_if",     0, 6'h3F, 6'h00, 0, 1, c_if(1));
    step("ill_id",     0, 6'h3F, 6'h00, 0, 1, cd(3'd1));
    step("ill_err",    0, 6'h3F, 6'h00, 0, 1, c_err(2'd1));
    step("ill_hold",   0, 6'h00, 6'h21, 0, 1, c_err(2'd1));
    step("ill_rst",    1, 6'h00, 6'h01, 0, 1, c_err(2'd1));

    // Illegal funct, starting from a clean post-reset IF
    step("illf_if",    0, 6'h00, 6'h01, 0, 1, c_if(1));
    step("illf_id",    0, 6'h00, 6'h01, 0, 1, cd(3'd1));
    step("illf_err",   0, 6'h00, 6'h01, 0, 1, c_err(2'd1));
    step("illf_rst",   1, 6'h02, 6'h00, 0, 0, c_err(2'd1));

    // Watchdog (TIMEOUT_CYC=4): 5 stalled IF cycles, then ERR code 2
    for (int i = 0; i < 5; i++)
      step("tmo_if_stall", 0, 6'h02, 6'h00, 0, 0, c_if(0));
    step("tmo_err",    0, 6'h02, 6'h00, 0, 0, c_err(2'd2));
    step("tmo_hold",   0, 6'h02, 6'h00, 0, 1, c_err(2'd2));
    step("tmo_rst",    1, 6'h02, 6'h00, 0, 0, c_err(2'd2));

    // Ready arrives on the match cycle: access completes, no trap
    for (int i = 0; i < 4; i++)
      step("race_if_stall", 0, 6'h02, 6'h00, 0, 0, c_if(0));
    step("race_if_rdy", 0, 6'h02, 6'h00, 0, 1, c_if(1));
    step("race_j_id",   0, 6'h02, 6'h00, 0, 1, c_jmp(2'd2, 0, 2'd0));
    step("race_back_if",0, 6'h02, 6'h00, 0, 1, c_if(1));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
